dvp_cam_tx: RTL and testbench
=============================

DVP_CAM_TX -- requirements
Module: dvp_cam_tx

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 144, blank pixel slots per line (href low).
REQ-004 The block SHALL have parameters VSYNC_LINES, VBP_LINES and VFP_LINES, defaults 3, 17 and 10, which set the vsync-high, back-porch and front-porch line counts.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, which is also the byte clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: run frames; it is sampled only at frame boundaries.
REQ-008 The block SHALL have port pix_data, input, 16 bits: RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
REQ-009 The block SHALL have port pix_valid, input, 1 bit: upstream pixel available.
REQ-010 The block SHALL have port pix_ready, output, 1 bit: the block accepts pix_data this cycle.
REQ-011 The block SHALL have port cam_vsync, output, 1 bit: DVP frame sync, active high.
REQ-012 The block SHALL have port cam_href, output, 1 bit: DVP line-valid.
REQ-013 The block SHALL have port cam_data, output, 8 bits: DVP data byte.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse in the first vsync-high cycle.
REQ-015 The block SHALL have port underrun, output, 1 bit: sticky flag meaning pixel data was missing during href.

Function
REQ-016 The block SHALL implement the states IDLE, VSYNC, VBP, ACTIVE and VFP; each line in VSYNC, VBP, ACTIVE and VFP SHALL last 2*(H_ACTIVE+H_BLANK) clocks.
REQ-017 From IDLE, the block SHALL enter VSYNC on the first clock at which enable=1; transitions SHALL be VSYNC->VBP->ACTIVE->VFP, each after its line count.
REQ-018 At the end of VFP, the block SHALL go to VSYNC if enable=1 and to IDLE otherwise; deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-019 cam_vsync SHALL be 1 exactly during VSYNC lines; cam_href SHALL be 1 for the first 2*H_ACTIVE clocks of each ACTIVE line and 0 elsewhere.
REQ-020 Per pixel, cam_data SHALL carry pix_data[15:8] on the first byte cycle and pix_data[7:0] on the second byte cycle.
REQ-021 pix_ready SHALL be 1 exactly one clock before each first-byte cycle of an active pixel; a transfer SHALL occur when pix_valid&pix_ready, and the block SHALL hold the low byte internally.
REQ-022 If pix_valid=0 while pix_ready=1, both bytes of that pixel SHALL be 0x00, underrun SHALL set, and the stream SHALL NOT stall (DVP has no backpressure).
REQ-023 cam_data SHALL be 0x00 whenever cam_href=0.
REQ-024 All DVP outputs SHALL be registered, with zero skew among vsync, href and data.
REQ-025 Counters SHALL wrap exactly at their limits (byte 0..2*(H_ACTIVE+H_BLANK)-1, line 0..count-1) with no extra cycle.
REQ-026 underrun SHALL clear only on reset.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously go to IDLE and clear counters; cam_vsync, cam_href, cam_data, pix_ready, frame_start and underrun SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; after release, the next frame SHALL start from VSYNC line 0.

Configuration
REQ-029 When TEST_PATTERN_EN is defined, an internal 8-bar colour pattern SHALL replace pix_data when pix_valid=0 at a transfer slot: bar = x*8/H_ACTIVE, in the order white, yellow, cyan, green, magenta, red, blue, black; underrun SHALL then never set.
REQ-030 When TEST_PATTERN_EN is undefined, the pattern logic SHALL be absent and REQ-022 SHALL apply.

Structure
REQ-031 The state enum, RGB565 bar constants and default timing constants SHALL live in the shared package cam_pkg.
REQ-032 The block SHALL contain one sub-module, dvp_timing_gen, which provides state, byte and line counters and strobes; dvp_cam_tx SHALL own the data path and handshake.

Verification
REQ-033 Test 1: with H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, all porches=1 and enable=1 from reset, the bench SHALL see frame period 5 lines x 12 clocks = 60 clocks, vsync high 12 clocks, and href high 8 clocks on lines 2 and 3.
REQ-034 Test 2: streaming pixels 0xF800, 0x07E0, 0x001F, 0xFFFF SHALL produce cam_data F8,00,07,E0,00,1F,FF,FF under href.
REQ-035 Test 3: pix_valid=0 for pixel 2 SHALL produce bytes 00,00 for that pixel, underrun=1 thereafter, and unchanged timing.
REQ-036 Test 4: enable dropped in the VBP line SHALL complete the frame through VFP and then stay in IDLE with all outputs 0.
REQ-037 Test 5: rst_n pulsed during the second ACTIVE line SHALL force outputs to 0 immediately; after release with enable=1, frame_start SHALL pulse on the first clock.
REQ-038 Test 6 (TEST_PATTERN_EN, H_ACTIVE=8, pix_valid=0): byte pairs SHALL be FF,FF / FF,E0 / 07,FF / 07,E0 / F8,1F / F8,00 / 00,1F / 00,00.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the DVP camera transmitter: FSM state encodings,
// default frame timing and the RGB565 colour-bar palette.
package cam_pkg;

  // Counter width for the byte and line counters; covers long lines and tall frames.
  localparam int CNT_W = 16;

  // Default VGA-style timing.
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_VBP_LINES   = 17;
  localparam int DEF_VFP_LINES   = 10;

  // Frame state encoding, kept as plain constants so older tools can consume it.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBP    = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFP    = 3'd4;

  // RGB565 colour bars, {R[4:0],G[5:0],B[4:0]}.
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Colour of bar 0..7, left to right.
  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_color = RGB_WHITE;
      3'd1:    bar_color = RGB_YELLOW;
      3'd2:    bar_color = RGB_CYAN;
      3'd3:    bar_color = RGB_GREEN;
      3'd4:    bar_color = RGB_MAGENTA;
      3'd5:    bar_color = RGB_RED;
      3'd6:    bar_color = RGB_BLUE;
      default: bar_color = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// DVP frame timing: frame FSM plus byte and line counters.
// Exports strobes describing the NEXT cycle so the parent can register its
// outputs from them and keep vsync, href and data perfectly aligned.
// Optional macro TEST_PATTERN_EN adds the colour-bar index output.
module dvp_timing_gen
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int VBP_LINES   = DEF_VBP_LINES,
  parameter int VFP_LINES   = DEF_VFP_LINES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       vsync_nxt,
  output logic       href_nxt,
  output logic       slot_nxt,
  output logic       fs_nxt
`ifdef TEST_PATTERN_EN
  ,
  output logic [2:0] bar_nxt
`endif
);

  localparam int LINE_CLKS = 2 * (H_ACTIVE + H_BLANK);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_q, byte_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] line_cnt;

  // Number of lines spent in the current state.
  always_comb begin
    case (state_q)
      ST_VSYNC:  line_cnt = CNT_W'(VSYNC_LINES);
      ST_VBP:    line_cnt = CNT_W'(VBP_LINES);
      ST_ACTIVE: line_cnt = CNT_W'(V_ACTIVE);
      ST_VFP:    line_cnt = CNT_W'(VFP_LINES);
      default:   line_cnt = CNT_W'(1);
    endcase
  end

  // Next-state and counter logic; enable is only looked at in IDLE and at the end of VFP.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_VSYNC;
        byte_d  = '0;
        line_d  = '0;
      end
    end else if (byte_q == CNT_W'(LINE_CLKS - 1)) begin
      byte_d = '0;
      if (line_q == line_cnt - 1'b1) begin
        line_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          default:   state_d = enable ? ST_VSYNC : ST_IDLE;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      byte_d = byte_q + 1'b1;
    end
  end

  // Strobes for the cycle described by the next-state values.
  always_comb begin
    vsync_nxt = (state_d == ST_VSYNC);
    href_nxt  = (state_d == ST_ACTIVE) && (byte_d < CNT_W'(2 * H_ACTIVE));
    slot_nxt  = href_nxt && !byte_d[0];
    fs_nxt    = (state_d == ST_VSYNC) && (line_d == '0) && (byte_d == '0);
  end

`ifdef TEST_PATTERN_EN
  logic [31:0] bar_wide;

  // Bar index of the pixel starting next cycle: x*8/H_ACTIVE.
  always_comb begin
    bar_wide = (32'(byte_d >> 1) * 32'd8) / 32'(H_ACTIVE);
    bar_nxt  = bar_wide[2:0];
  end
`endif

  // Frame state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q <= state_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP camera transmitter: serialises RGB565 pixels into high/low bytes under
// vsync/href framing. Timing comes from dvp_timing_gen; this module owns the
// pixel handshake, the byte data path and the sticky underrun flag.
// Optional macro TEST_PATTERN_EN fills missing pixels with 8 colour bars.
module dvp_cam_tx
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int VBP_LINES   = DEF_VBP_LINES,
  parameter int VFP_LINES   = DEF_VFP_LINES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        underrun
);

  logic vsync_nxt, href_nxt, slot_nxt, fs_nxt;
`ifdef TEST_PATTERN_EN
  logic [2:0] bar_nxt;
`endif

  dvp_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .VBP_LINES   (VBP_LINES),
    .VFP_LINES   (VFP_LINES)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .vsync_nxt (vsync_nxt),
    .href_nxt  (href_nxt),
    .slot_nxt  (slot_nxt),
    .fs_nxt    (fs_nxt)
`ifdef TEST_PATTERN_EN
    ,
    .bar_nxt   (bar_nxt)
`endif
  );

  logic       cam_vsync_q, cam_vsync_d;
  logic       cam_href_q, cam_href_d;
  logic [7:0] cam_data_q, cam_data_d;
  logic       frame_start_q, frame_start_d;
  logic       underrun_q, underrun_d;
  logic [7:0] lo_q, lo_d;

  // The pixel is taken in the cycle before its first byte goes out.
  assign pix_ready = slot_nxt;

  // Byte path: high byte on the transfer edge, held low byte on the next; 0x00 outside href.
  always_comb begin
    cam_vsync_d   = vsync_nxt;
    cam_href_d    = href_nxt;
    frame_start_d = fs_nxt;
    cam_data_d    = 8'h00;
    lo_d          = lo_q;
    underrun_d    = underrun_q;
    if (slot_nxt) begin
      if (pix_valid) begin
        cam_data_d = pix_data[15:8];
        lo_d       = pix_data[7:0];
      end else begin
`ifdef TEST_PATTERN_EN
        {cam_data_d, lo_d} = bar_color(bar_nxt);
`else
        // No backpressure on DVP: send a black pixel and flag it.
        cam_data_d = 8'h00;
        lo_d       = 8'h00;
        underrun_d = 1'b1;
`endif
      end
    end else if (href_nxt) begin
      cam_data_d = lo_q;
    end
  end

  // Registered DVP outputs, handshake state and sticky underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vsync_q   <= 1'b0;
      cam_href_q    <= 1'b0;
      cam_data_q    <= 8'h00;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      // NOTE: the low-byte holding register is reset too; it is tiny and a known value eases debug.
      lo_q          <= 8'h00;
    end else begin
      cam_vsync_q   <= cam_vsync_d;
      cam_href_q    <= cam_href_d;
      cam_data_q    <= cam_data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      lo_q          <= lo_d;
    end
  end

  assign cam_vsync   = cam_vsync_q;
  assign cam_href    = cam_href_q;
  assign cam_data    = cam_data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Directed bench for dvp_cam_tx with a tiny frame: H_ACTIVE=4, V_ACTIVE=2,
// H_BLANK=2, one line of each porch -> 5 lines x 12 clocks per frame.
// Frame layout: line 0 vsync (k 0..11), line 1 back porch, lines 2,3 active
// (href k 24..31 and 36..43), line 4 front porch.
module tb_dvp_cam_tx;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic        underrun;

  dvp_cam_tx #(
    .H_ACTIVE    (4),
    .V_ACTIVE    (2),
    .H_BLANK     (2),
    .VSYNC_LINES (1),
    .VBP_LINES   (1),
    .VFP_LINES   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

`ifdef TEST_PATTERN_EN
  logic       tp_ready, tp_vsync, tp_href, tp_fs, tp_ur;
  logic [7:0] tp_data;

  dvp_cam_tx #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (1),
    .H_BLANK     (2),
    .VSYNC_LINES (1),
    .VBP_LINES   (1),
    .VFP_LINES   (1)
  ) dut_tp (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (1'b1),
    .pix_data    (16'h1234),
    .pix_valid   (1'b0),
    .pix_ready   (tp_ready),
    .cam_vsync   (tp_vsync),
    .cam_href    (tp_href),
    .cam_data    (tp_data),
    .frame_start (tp_fs),
    .underrun    (tp_ur)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic        vs_a [64];
  logic        hr_a [64];
  logic        fs_a [64];
  logic        rdy_a[64];
  logic        ur_a [64];
  logic [7:0]  dat_a[64];
  logic [15:0] pix_tab[4];
  logic [7:0]  exp_line[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run n cycles from the next clock edge, sampling 1 ns after each edge and
  // answering pix_ready with the pixel table (pixel drop_idx sent invalid).
  task automatic run_frame(input int n, input int drop_idx, input int en_off_at);
    int pix_n;
    pix_n = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      vs_a[i]  = cam_vsync;
      hr_a[i]  = cam_href;
      fs_a[i]  = frame_start;
      rdy_a[i] = pix_ready;
      ur_a[i]  = underrun;
      dat_a[i] = cam_data;
      if (i == en_off_at) enable = 1'b0;
      if (pix_ready) begin
        pix_data  = pix_tab[pix_n % 4];
        pix_valid = (pix_n != drop_idx);
        pix_n++;
      end else begin
        pix_data  = 16'hDEAD;
        pix_valid = 1'b0;
      end
    end
  endtask

  function automatic int count_hi(input logic a[64], input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) if (a[i]) c++;
    return c;
  endfunction

  // Number of cycles in [lo,hi] where data is non-zero while href is low.
  function automatic int data_outside_href(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i <= hi; i++) if (!hr_a[i] && dat_a[i] != 8'h00) c++;
    return c;
  endfunction

  int          ur_exp;
  logic [7:0]  drop_hi, drop_lo;
  logic [7:0]  tp_exp[16];
  int          found;

  initial begin
    pix_tab  = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
    exp_line = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    rst_n     = 1'b0;
    enable    = 1'b1;
    pix_data  = 16'h0000;
    pix_valid = 1'b0;

    // Reset state.
    #22;
    check("rst_vsync", 32'(cam_vsync), 32'd0);
    check("rst_href", 32'(cam_href), 32'd0);
    check("rst_data", 32'(cam_data), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    #6 rst_n = 1'b1;

    // Test 1 + 2: timing and byte order with all pixels valid.
    run_frame(60, -1, -1);
    check("t1_fs_first", 32'(fs_a[0]), 32'd1);
    check("t1_fs_count", 32'(count_hi(fs_a, 0, 59)), 32'd1);
    check("t1_vsync_first", 32'(vs_a[0]), 32'd1);
    check("t1_vsync_count", 32'(count_hi(vs_a, 0, 59)), 32'd12);
    check("t1_vsync_end", 32'(vs_a[12]), 32'd0);
    check("t1_href_count", 32'(count_hi(hr_a, 0, 59)), 32'd16);
    check("t1_href_l2_pre", 32'(hr_a[23]), 32'd0);
    check("t1_href_l2_start", 32'(hr_a[24]), 32'd1);
    check("t1_href_l2_last", 32'(hr_a[31]), 32'd1);
    check("t1_href_l2_post", 32'(hr_a[32]), 32'd0);
    check("t1_href_l3_start", 32'(hr_a[36]), 32'd1);
    check("t1_href_l3_post", 32'(hr_a[44]), 32'd0);
    check("t1_ready_count", 32'(count_hi(rdy_a, 0, 59)), 32'd8);
    check("t1_ready_first", 32'(rdy_a[23]), 32'd1);
    check("t1_ready_gap", 32'(rdy_a[24]), 32'd0);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("t2_l2_byte%0d", b), 32'(dat_a[24 + b]), 32'(exp_line[b]));
      check($sformatf("t2_l3_byte%0d", b), 32'(dat_a[36 + b]), 32'(exp_line[b]));
    end
    check("t1_data_zero_off_href", 32'(data_outside_href(0, 59)), 32'd0);
    check("t1_underrun", 32'(ur_a[59]), 32'd0);

    // Test 3: second pixel of the frame missing.
`ifdef TEST_PATTERN_EN
    drop_hi = 8'h07; drop_lo = 8'hFF; ur_exp = 0;
`else
    drop_hi = 8'h00; drop_lo = 8'h00; ur_exp = 1;
`endif
    run_frame(60, 1, -1);
    check("t3_fs_period", 32'(fs_a[0]), 32'd1);
    check("t3_href_count", 32'(count_hi(hr_a, 0, 59)), 32'd16);
    check("t3_vsync_count", 32'(count_hi(vs_a, 0, 59)), 32'd12);
    check("t3_byte0", 32'(dat_a[24]), 32'h00F8);
    check("t3_byte1", 32'(dat_a[25]), 32'h0000);
    check("t3_drop_hi", 32'(dat_a[26]), 32'(drop_hi));
    check("t3_drop_lo", 32'(dat_a[27]), 32'(drop_lo));
    check("t3_byte4", 32'(dat_a[28]), 32'h0000);
    check("t3_byte5", 32'(dat_a[29]), 32'h001F);
    check("t3_l3_byte3", 32'(dat_a[39]), 32'h00E0);
    check("t3_ur_before", 32'(ur_a[25]), 32'd0);
    check("t3_ur_after", 32'(ur_a[26]), 32'(ur_exp));
    check("t3_ur_sticky", 32'(ur_a[59]), 32'(ur_exp));

    // Test 4: enable dropped during the back-porch line; frame still completes.
    run_frame(60, -1, 14);
    check("t4_fs", 32'(fs_a[0]), 32'd1);
    check("t4_href_count", 32'(count_hi(hr_a, 0, 59)), 32'd16);
    check("t4_byte0", 32'(dat_a[36]), 32'h00F8);
    run_frame(24, -1, -1);
    check("t4_idle_fs", 32'(count_hi(fs_a, 0, 23)), 32'd0);
    check("t4_idle_vsync", 32'(count_hi(vs_a, 0, 23)), 32'd0);
    check("t4_idle_href", 32'(count_hi(hr_a, 0, 23)), 32'd0);
    check("t4_idle_ready", 32'(count_hi(rdy_a, 0, 23)), 32'd0);
    check("t4_idle_data", 32'(data_outside_href(0, 23)), 32'd0);

    // Test 5: reset pulsed during the second active line.
    enable = 1'b1;
    run_frame(38, -1, -1);
    check("t5_fs", 32'(fs_a[0]), 32'd1);
    check("t5_href_before", 32'(hr_a[37]), 32'd1);
    check("t5_ur_before", 32'(ur_a[37]), 32'(ur_exp));
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_vsync", 32'(cam_vsync), 32'd0);
    check("t5_rst_href", 32'(cam_href), 32'd0);
    check("t5_rst_data", 32'(cam_data), 32'd0);
    check("t5_rst_ready", 32'(pix_ready), 32'd0);
    check("t5_rst_fs", 32'(frame_start), 32'd0);
    check("t5_rst_underrun", 32'(underrun), 32'd0);
    #3 rst_n = 1'b1;
    run_frame(61, -1, -1);
    check("t5_fs_first_clk", 32'(fs_a[0]), 32'd1);
    check("t5_vsync_first_clk", 32'(vs_a[0]), 32'd1);
    check("t5_fs_second", 32'(fs_a[1]), 32'd0);
    check("t5_vsync_count", 32'(count_hi(vs_a, 0, 59)), 32'd12);
    check("t5_href_l2_start", 32'(hr_a[24]), 32'd1);
    check("t5_byte0", 32'(dat_a[24]), 32'h00F8);
    check("t5_next_frame", 32'(fs_a[60]), 32'd1);
    check("t5_underrun", 32'(ur_a[60]), 32'd0);

`ifdef TEST_PATTERN_EN
    // Test 6: colour bars from the H_ACTIVE=8 instance (pix_valid tied low).
    tp_exp = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
               8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (tp_href) found = 1;
    end
    check("t6_href_seen", 32'(found), 32'd1);
    for (int b = 0; b < 16; b++) begin
      if (b > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("t6_byte%0d", b), 32'(tp_data), 32'(tp_exp[b]));
    end
    check("t6_underrun", 32'(tp_ur), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
